// File: rtl/mem_access_pkg.sv
// Shared MEM-stage definitions: instruction-type encodings, FSM states,
// byte-count constants and small decode helpers.
package mem_access_pkg;

  localparam int unsigned INST_TYPE_W = 6;
  localparam int unsigned REG_W       = 32;
  localparam int unsigned MEM_BYTE_W  = 8;

  localparam logic [4:0] NOP_REG_ADDR = 5'd0;

  localparam logic [INST_TYPE_W-1:0] INST_LB  = 6'd16;
  localparam logic [INST_TYPE_W-1:0] INST_LH  = 6'd17;
  localparam logic [INST_TYPE_W-1:0] INST_LW  = 6'd18;
  localparam logic [INST_TYPE_W-1:0] INST_LBU = 6'd19;
  localparam logic [INST_TYPE_W-1:0] INST_LHU = 6'd20;
  localparam logic [INST_TYPE_W-1:0] INST_SB  = 6'd21;
  localparam logic [INST_TYPE_W-1:0] INST_SH  = 6'd22;
  localparam logic [INST_TYPE_W-1:0] INST_SW  = 6'd23;

  localparam logic [2:0] MEM_BYTES_1 = 3'd1;
  localparam logic [2:0] MEM_BYTES_2 = 3'd2;
  localparam logic [2:0] MEM_BYTES_4 = 3'd4;

  typedef enum logic [1:0] {
    MEM_IDLE   = 2'd0,
    MEM_ACCESS = 2'd1,
    MEM_DONE   = 2'd2
  } mem_state_e;

  function automatic logic [2:0] mem_byte_count(input logic [INST_TYPE_W-1:0] t);
    case (t)
      INST_LB, INST_LBU, INST_SB: mem_byte_count = MEM_BYTES_1;
      INST_LH, INST_LHU, INST_SH: mem_byte_count = MEM_BYTES_2;
      INST_LW, INST_SW:           mem_byte_count = MEM_BYTES_4;
      default:                    mem_byte_count = MEM_BYTES_4;
    endcase
  endfunction

  function automatic logic mem_misaligned(input logic [INST_TYPE_W-1:0] t,
                                          input logic [1:0] a);
    case (t)
      INST_LH, INST_LHU, INST_SH: mem_misaligned = a[0];
      INST_LW, INST_SW:           mem_misaligned = (a != 2'b00);
      default:                    mem_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_load_ext.sv
// Load-value extension: takes the little-endian assembled bytes and applies
// sign or zero extension according to the load type.
module mem_load_ext
  import mem_access_pkg::*;
(
  input  logic [INST_TYPE_W-1:0] inst_type_in,
  input  logic [REG_W-1:0]       raw_in,
  output logic [REG_W-1:0]       val_out
);

  always_comb begin
    case (inst_type_in)
      INST_LB:  val_out = {{24{raw_in[7]}}, raw_in[7:0]};
      INST_LBU: val_out = {24'd0, raw_in[7:0]};
      INST_LH:  val_out = {{16{raw_in[15]}}, raw_in[15:0]};
      INST_LHU: val_out = {16'd0, raw_in[15:0]};
      default:  val_out = raw_in;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage: pass-through for non-memory ops, byte-serial load/store on the
// shared 8-bit RAM port with a pipeline stall request.
// Optional alignment trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rd_in,
  input  logic [4:0]             rd_addr_in,
  input  logic [REG_W-1:0]       rd_val_in,
  input  logic [INST_TYPE_W-1:0] inst_type_in,
  input  logic                   load_in,
  input  logic                   store_in,
  input  logic [31:0]            mem_addr_in,
  input  logic [31:0]            mem_val_in,
  input  logic                   stall_in,
  input  logic                   ram_grant_in,
  input  logic [MEM_BYTE_W-1:0]  ram_din_in,
  output logic                   ram_req_out,
  output logic                   ram_wr_out,
  output logic [ADDR_W-1:0]      ram_addr_out,
  output logic [MEM_BYTE_W-1:0]  ram_dout_out,
  output logic                   rd_out,
  output logic [4:0]             rd_addr_out,
  output logic [REG_W-1:0]       rd_val_out,
  output logic                   stallreq_from_mem
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic                   misalign_out
`endif
);

  mem_state_e       state_q, state_d;
  logic [2:0]       issue_cnt_q, issue_cnt_d;
  logic [2:0]       cap_cnt_q, cap_cnt_d;
  logic             rd_pend_q, rd_pend_d;
  logic [REG_W-1:0] asm_q, asm_d;

  logic [2:0]       n_bytes;
  logic             is_mem, is_load, is_store;
  logic [31:0]      byte_addr;
  logic [7:0]       st_byte;
  logic [REG_W-1:0] ld_ext;

  mem_load_ext u_load_ext (
    .inst_type_in (inst_type_in),
    .raw_in       (asm_q),
    .val_out      (ld_ext)
  );

  always_comb begin
    n_bytes   = mem_byte_count(inst_type_in);
    is_mem    = load_in | store_in;
    is_load   = load_in;
    is_store  = store_in & ~load_in;
    byte_addr = mem_addr_in + {29'd0, issue_cnt_q};
    case (issue_cnt_q[1:0])
      2'd0:    st_byte = mem_val_in[7:0];
      2'd1:    st_byte = mem_val_in[15:8];
      2'd2:    st_byte = mem_val_in[23:16];
      default: st_byte = mem_val_in[31:24];
    endcase
  end

  always_comb begin
    state_d           = state_q;
    issue_cnt_d       = issue_cnt_q;
    cap_cnt_d         = cap_cnt_q;
    rd_pend_d         = 1'b0;
    asm_d             = asm_q;
    ram_req_out       = 1'b0;
    ram_wr_out        = 1'b0;
    ram_addr_out      = '0;
    ram_dout_out      = '0;
    rd_out            = 1'b0;
    rd_addr_out       = NOP_REG_ADDR;
    rd_val_out        = '0;
    stallreq_from_mem = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    misalign_out      = 1'b0;
`endif

    case (state_q)
      MEM_IDLE: begin
        if (!is_mem) begin
          rd_out      = rd_in;
          rd_addr_out = rd_addr_in;
          rd_val_out  = rd_val_in;
        end
`ifdef MEM_ALIGN_CHECK_EN
        else if (mem_misaligned(inst_type_in, mem_addr_in[1:0])) begin
          misalign_out = 1'b1;
        end
`endif
        else begin
          stallreq_from_mem = 1'b1;
          ram_req_out       = 1'b1;
          ram_wr_out        = is_store;
          state_d           = MEM_ACCESS;
          if (ram_grant_in) begin
            ram_addr_out = ADDR_W'(byte_addr);
            ram_dout_out = is_store ? st_byte : '0;
            issue_cnt_d  = issue_cnt_q + 3'd1;
            rd_pend_d    = is_load;
            // A single-byte store completes on its only write cycle.
            if (is_store && n_bytes == MEM_BYTES_1) state_d = MEM_DONE;
          end
        end
      end

      MEM_ACCESS: begin
        stallreq_from_mem = 1'b1;
        // Capture runs off the previous cycle's issue, independent of grant.
        if (rd_pend_q) begin
          asm_d[{cap_cnt_q[1:0], 3'b000} +: 8] = ram_din_in;
          cap_cnt_d = cap_cnt_q + 3'd1;
          if (is_load && cap_cnt_q == n_bytes - 3'd1) state_d = MEM_DONE;
        end
        if (issue_cnt_q < n_bytes) begin
          ram_req_out = 1'b1;
          ram_wr_out  = is_store;
          if (ram_grant_in) begin
            ram_addr_out = ADDR_W'(byte_addr);
            ram_dout_out = is_store ? st_byte : '0;
            issue_cnt_d  = issue_cnt_q + 3'd1;
            rd_pend_d    = is_load;
            if (is_store && issue_cnt_q == n_bytes - 3'd1) state_d = MEM_DONE;
          end
        end
      end

      MEM_DONE: begin
        rd_out      = rd_in;
        rd_addr_out = rd_addr_in;
        rd_val_out  = is_load ? ld_ext : rd_val_in;
        if (!stall_in) begin
          state_d     = MEM_IDLE;
          issue_cnt_d = '0;
          cap_cnt_d   = '0;
          asm_d       = '0;
        end
      end

      default: state_d = MEM_IDLE;
    endcase

    if (rst_in) begin
      ram_req_out       = 1'b0;
      ram_wr_out        = 1'b0;
      ram_addr_out      = '0;
      ram_dout_out      = '0;
      rd_out            = 1'b0;
      rd_addr_out       = NOP_REG_ADDR;
      rd_val_out        = '0;
      stallreq_from_mem = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_out      = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= MEM_IDLE;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
      rd_pend_q   <= 1'b0;
      asm_q       <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      rd_pend_q   <= rd_pend_d;
      asm_q       <= asm_d;
    end
  end

endmodule
